// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial accelerator host controller.
// Imported by the controller top and its counter sub-module.
package fact_pkg;

  localparam int FACT_W        = 32;
  localparam int N_W           = 4;
  localparam int MAX_N_DEFAULT = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3
  } state_e;

  // True when n! still fits the result word for the given limit.
  function automatic logic n_in_range(input logic [N_W-1:0] n, input int max_n);
    return (int'({28'd0, n}) <= max_n);
  endfunction

endpackage

// File: rtl/fact_timeout_cnt.sv
// Clear/enable up-counter with a terminal-count flag.
// Serves as the done-timeout counter and as the wrapping job counter.
module fact_timeout_cnt #(
  parameter int W    = 16,
  parameter int TERM = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] TERM_V = W'(TERM);
  localparam logic [W-1:0] ONE_V  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority over counting; the count wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE_V;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TERM_V);

endmodule

// File: rtl/fact_host_ctrl.sv
// Host-side initiator for the factorial accelerator go/A/Result/done handshake.
// Takes a job on a valid/ready request port and returns n! (or an error) on a response port.
module fact_host_ctrl
  import fact_pkg::*;
#(
  parameter int MAX_N       = MAX_N_DEFAULT,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [N_W-1:0]    req_n,
  output logic              req_ready,
  output logic              res_valid,
  output logic [FACT_W-1:0] res_data,
  output logic              res_err,
  input  logic              res_ready,
  output logic              go,
  output logic [N_W-1:0]    A,
  input  logic [FACT_W-1:0] Result,
  input  logic              done,
  output logic [2:0]        cs,
  output logic [CNT_W-1:0]  jobs_done
);

  state_e            state_q;
  logic              go_q;
  logic [N_W-1:0]    a_q;
  logic              res_valid_q;
  logic [FACT_W-1:0] res_data_q;
  logic              res_err_q;

  logic              req_ready_s;
  logic              tmo_tc_s;
  logic              jobs_en_s;
  logic [CNT_W-1:0]  tmo_cnt_unused_s;
  logic              jobs_tc_unused_s;

  // A lingering done from the previous job blocks a new launch.
  assign req_ready_s = (state_q == S_IDLE) && !done;
  assign jobs_en_s   = (state_q == S_RESP) && res_valid_q && res_ready && !res_err_q;

  fact_timeout_cnt #(
    .W    (CNT_W),
    .TERM (TIMEOUT_CYC - 1)
  ) u_tmo_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_q == S_LAUNCH),
    .en_i  (state_q == S_WAIT),
    .cnt_o (tmo_cnt_unused_s),
    .tc_o  (tmo_tc_s)
  );

  fact_timeout_cnt #(
    .W    (CNT_W),
    .TERM (0)
  ) u_jobs_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (1'b0),
    .en_i  (jobs_en_s),
    .cnt_o (jobs_done),
    .tc_o  (jobs_tc_unused_s)
  );

  // Job sequencing FSM; every handshake output is registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      go_q        <= 1'b0;
      a_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_s) begin
            if (n_in_range(req_n, MAX_N)) begin
              a_q     <= req_n;
              state_q <= S_LAUNCH;
            end else begin
              res_data_q  <= '0;
              res_err_q   <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          go_q    <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // done beats a simultaneous timeout so a late-but-valid result is kept.
          if (done) begin
            go_q        <= 1'b0;
            res_data_q  <= Result;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (tmo_tc_s) begin
            go_q        <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_RESP: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_RESP;
          end
        end
        default: begin
          go_q        <= 1'b0;
          res_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign go        = go_q;
  assign A         = a_q;
  assign cs        = state_q;

endmodule

// File: tb/tb_fact_host_ctrl.sv
// Directed bench for fact_host_ctrl with a behavioural accelerator and a job-level model.
module tb_fact_host_ctrl;
  import fact_pkg::*;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_n = 4'd0;
  logic        req_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_ready = 1'b0;
  logic        go;
  logic [3:0]  A;
  logic [31:0] Result = 32'hDEADBEEF;
  logic        done = 1'b0;
  logic [2:0]  cs;
  logic [15:0] jobs_done;

  int vectors = 0;
  int miscompares = 0;

  // Job-level expectations shared with the per-cycle compare process.
  logic        exp_pending = 1'b0;
  logic [31:0] exp_data = 32'd0;
  logic        exp_err = 1'b0;
  logic        go_allowed = 1'b0;
  logic [15:0] exp_jobs = 16'd0;
  logic        started = 1'b0;
  logic        never_done = 1'b0;
  int          gcnt = 0;

  always #5 clk = ~clk;

  fact_host_ctrl #(.MAX_N(12), .TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .res_ready(res_ready),
    .go(go), .A(A), .Result(Result), .done(done), .cs(cs), .jobs_done(jobs_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fact(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  // Accelerator: done rises n+3 cycles after go, holds while go, drops a cycle after go falls.
  always @(posedge clk) begin
    if (go) begin
      gcnt <= gcnt + 1;
      if (!never_done && !done && (gcnt + 1 == int'(A) + 3)) begin
        done   <= 1'b1;
        Result <= fact(int'(A));
      end
    end else begin
      gcnt   <= 0;
      done   <= 1'b0;
      Result <= 32'hDEADBEEF;
    end
  end

  // Model count of good responses consumed.
  always @(posedge clk) begin
    if (!rst) exp_jobs <= 16'd0;
    else if (res_valid && res_ready && exp_pending && !exp_err) exp_jobs <= exp_jobs + 16'd1;
  end

  // Per-cycle compare of the DUT against the job model.
  always @(posedge clk) begin
    #2;
    if (started) begin
      chk("jobs_done", 32'(jobs_done), 32'(exp_jobs));
      if (res_valid) begin
        chk("resp_expected", 32'(exp_pending), 32'd1);
        chk("res_data", res_data, exp_data);
        chk("res_err", 32'(res_err), 32'(exp_err));
      end
      if (!go_allowed) chk("go_idle", 32'(go), 32'd0);
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_job(input logic [3:0] n, input logic [31:0] lit_data,
                        input logic lit_err, input int hold);
    logic [31:0] m_data;
    logic        m_err;
    int          m_go;
    int          gocnt;
    int          w;
    if (n > 4'd12) begin
      m_data = 32'd0; m_err = 1'b1; m_go = 0;
    end else if (never_done) begin
      m_data = 32'd0; m_err = 1'b1; m_go = TMO;
    end else begin
      m_data = fact(int'(n)); m_err = 1'b0; m_go = int'(n) + 4;
    end
    chk("model_data", m_data, lit_data);
    chk("model_err", 32'(m_err), 32'(lit_err));
    wait_ready();
    exp_data = m_data; exp_err = m_err; exp_pending = 1'b1; go_allowed = (m_go != 0);
    req_valid = 1'b1; req_n = n; res_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0; req_n = ~n;
    if (n > 4'd12) begin
      chk("range_res_valid", 32'(res_valid), 32'd1);
      chk("range_cs", 32'(cs), 32'd3);
      chk("range_go", 32'(go), 32'd0);
    end else begin
      chk("launch_cs", 32'(cs), 32'd1);
      chk("launch_A", 32'(A), 32'(n));
      chk("launch_go", 32'(go), 32'd0);
      gocnt = 0; w = 0;
      while (!res_valid && w < 400) begin
        @(negedge clk);
        if (w == 0) chk("go_rise", 32'(go), 32'd1);
        if (go) gocnt++;
        w++;
      end
      chk("res_valid_seen", 32'(res_valid), 32'd1);
      chk("go_cycles", 32'(gocnt), 32'(m_go));
      chk("go_dropped", 32'(go), 32'd0);
      chk("A_hold", 32'(A), 32'(n));
      go_allowed = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_cs", 32'(cs), 32'd3);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("resp_cleared", 32'(res_valid), 32'd0);
    chk("back_idle", 32'(cs), 32'd0);
    res_ready = 1'b0;
    exp_pending = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    started = 1'b1;
    chk("rst_cs", 32'(cs), 32'd0);
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_A", 32'(A), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_jobs", 32'(jobs_done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("pin_fact12", fact(12), 32'h1C8CFC00);

    do_job(4'd2, 32'd2, 1'b0, 0);
    chk("jobs_after_2", 32'(jobs_done), 32'd1);
    do_job(4'd10, 32'd3628800, 1'b0, 0);
    do_job(4'd12, 32'd479001600, 1'b0, 0);
    chk("jobs_after_12", 32'(jobs_done), 32'd3);
    do_job(4'd13, 32'd0, 1'b1, 0);
    do_job(4'd15, 32'd0, 1'b1, 0);
    chk("jobs_after_range", 32'(jobs_done), 32'd3);
    do_job(4'd0, 32'd1, 1'b0, 0);
    do_job(4'd3, 32'd6, 1'b0, 20);
    chk("jobs_after_hold", 32'(jobs_done), 32'd5);

    never_done = 1'b1;
    do_job(4'd5, 32'd0, 1'b1, 0);
    never_done = 1'b0;
    chk("jobs_after_tmo", 32'(jobs_done), 32'd5);

    // Reset in the middle of an n=10 wait: no response may follow.
    wait_ready();
    exp_pending = 1'b0; go_allowed = 1'b1;
    req_valid = 1'b1; req_n = 4'd10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_wait_go", 32'(go), 32'd1);
    chk("mid_wait_cs", 32'(cs), 32'd2);
    rst = 1'b0; go_allowed = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort_go", 32'(go), 32'd0);
    chk("abort_cs", 32'(cs), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_jobs", 32'(jobs_done), 32'd0);
    repeat (20) @(negedge clk);
    do_job(4'd4, 32'd24, 1'b0, 0);
    chk("jobs_after_abort", 32'(jobs_done), 32'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fact_host_ctrl.md
Name: fact_host_ctrl

Overview:
- Host-side initiator for the factorial accelerator's go/A/Result/done handshake.
- Accepts a job request (n) on a valid/ready port and launches the accelerator.
- Waits for done with a timeout, captures Result, and returns it on a valid/ready response port.
- Sits between the processor's accelerator interface and the factorial core, and replaces hand-driven go/A stimulus.

Parameters:
- MAX_N, 12, largest n whose factorial fits in 32 bits; n > MAX_N is rejected without launching.
- TIMEOUT_CYC, 255, number of cycles to wait for done before aborting (1..65535).
- CNT_W, 16, width of the timeout counter and the job counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (sampled low at a rising edge resets the block).
- req_valid  in  1  host presents a job.
- req_n  in  4  operand n.
- req_ready  out  1  block can accept a job this cycle.
- res_valid  out  1  response available.
- res_data  out  32  factorial result; 0 on error.
- res_err  out  1  response is an error (range or timeout).
- res_ready  in  1  host consumes the response.
- go  out  1  launch level to the accelerator.
- A  out  4  operand to the accelerator.
- Result  in  32  accelerator result.
- done  in  1  accelerator completion.
- cs  out  3  current-state encoding, for debug.
- jobs_done  out  CNT_W  count of successful (non-error) responses accepted; wraps.

Behaviour:
- Reset (rst low at an edge), regardless of state:
  - state = IDLE; go = 0; A = 0; res_valid = 0; res_data = 0; res_err = 0; timeout counter = 0; jobs_done = 0.
  - A reset during WAIT drops go on the next edge. No response is issued for the aborted job.
- States and cs encoding: IDLE = 3'd0, LAUNCH = 3'd1, WAIT = 3'd2, RESP = 3'd3. Codes 4–7 are illegal and recover to IDLE on the next edge.
- req_ready = (state == IDLE) && !done. The block never launches while the accelerator still reports done from a previous job.
- IDLE:
  - Handshake (req_valid && req_ready) at edge T with req_n <= MAX_N: A <= req_n, state -> LAUNCH.
  - Handshake with req_n > MAX_N: res_data <= 0, res_err <= 1, res_valid <= 1, state -> RESP. go is never asserted.
- LAUNCH (1 cycle): go <= 1, timeout counter <= 0, state -> WAIT. go is first high in cycle T+2 relative to acceptance edge T.
- WAIT:
  - go held high; A held stable; counter increments each cycle.
  - done sampled high at edge D: res_data <= Result, res_err <= 0, res_valid <= 1, go <= 0, state -> RESP. Result is captured at the same edge done is seen.
  - Counter reaches TIMEOUT_CYC-1 with done low: go <= 0, res_data <= 0, res_err <= 1, res_valid <= 1, state -> RESP.
  - done and the timeout in the same cycle: done wins and the result is good.
- RESP:
  - res_valid, res_data and res_err held stable until res_ready.
  - On res_valid && res_ready: res_valid <= 0, state -> IDLE. If res_err == 0, jobs_done increments (wrapping at 2^CNT_W).
  - Back-to-back: the next request is accepted only once state is IDLE and done is low. Minimum spacing is therefore 1 idle cycle.
- A changes only on request acceptance. go is never high outside LAUNCH/WAIT exit timing. req_n and Result are never used combinationally to drive outputs.

Decomposition:
- Shared package fact_pkg: state encodings (S_IDLE, S_LAUNCH, S_WAIT, S_RESP), FACT_W = 32, N_W = 4, default MAX_N = 12.
- One natural sub-module, fact_timeout_cnt: a clear/enable counter with a terminal-count flag, also reusable for jobs_done.
- Bench uses a behavioural accelerator model: done rises n+3 cycles after go, stays high while go is high, and falls one cycle after go drops.

Test Plan:
- req_n = 2, res_ready = 1 -> go high 2 cycles after accept; res_valid with res_data = 2, res_err = 0; jobs_done = 1.
- req_n = 10 -> res_data = 32'd3628800 (0x00375F00); req_n = 12 -> 32'd479001600 (0x1C8CFC00); jobs_done increments once per job.
- req_n = 13 -> res_valid the cycle after accept, res_err = 1, res_data = 0; go never asserted; jobs_done unchanged.
- Model never raises done, TIMEOUT_CYC = 255 -> res_err = 1 exactly 255 WAIT cycles after go rises; go low from then on.
- res_ready held low for 20 cycles after a result of 6 (n = 3) -> res_data stays 6, res_valid stays high, req_ready stays 0. On release, return to IDLE.
- rst driven low for one edge mid-WAIT of an n = 10 job -> go = 0, cs = 0, res_valid = 0 the next cycle, no response. A new job with n = 4 then returns 24.
